int_alu_fu: RTL
===============

// Module: int_alu_fu
// PURPOSE
//  Pipelined integer ALU functional unit for the Tomasulo core; successor to the single-cycle add/sub unit.
//  Accepts one dispatched op per cycle from the ALU reservation station and computes in a LATENCY-deep pipeline.
//  Buffers results in an in-order output queue until the CDB arbiter grants a broadcast slot.
//  Credit-based: never accepts an op it cannot later buffer, so the pipeline itself never stalls.
// PARAMETERS
//  XLEN        32  operand/result width
//  TAG_W       4   ROB/RS tag width
//  LATENCY     2   pipeline stages from accept to queue entry (>=1)
//  OUTQ_DEPTH  2   max ops in flight + queued (>=1); output queue depth
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high
//  flush        in   1      sync squash of all in-flight/queued ops (mispredict)
//  issue_valid  in   1      RS presents an op
//  issue_ready  out  1      unit can accept an op this cycle
//  issue_op     in   4      opcode (see BEHAVIOUR)
//  issue_a      in   XLEN   operand A
//  issue_b      in   XLEN   operand B
//  issue_tag    in   TAG_W  destination tag
//  cdb_req      out  1      queue head valid, requesting CDB
//  cdb_tag      out  TAG_W  head tag
//  cdb_result   out  XLEN   head result
//  cdb_grant    in   1      arbiter accepts head this cycle
//  busy         out  1      any op in flight or queued
// BEHAVIOUR
//  Reset (async): pipeline valids, queue, credit count cleared; cdb_req=0, cdb_tag=0, cdb_result=0,
//   busy=0, issue_ready=1. Reset mid-operation discards everything; no broadcast after release.
//  Accept = issue_valid & issue_ready. issue_ready = (cnt < OUTQ_DEPTH), cnt = in-flight + queued,
//   from registered cnt only (a grant in the same cycle does not raise ready until next cycle).
//  cnt: +1 on accept, -1 on grant (cdb_req & cdb_grant), both -> unchanged.
//  Latency: op accepted at edge N enters queue at edge N+LATENCY; cdb_req high from then on.
//  Queue: FIFO, in order of acceptance; head drives cdb_tag/cdb_result combinationally from storage;
//   pop on grant; simultaneous push+pop legal, incl. when full or empty-to-one.
//  cdb_grant while cdb_req=0 ignored. Outputs hold stable while cdb_req=1 and no grant.
//  Ops (mod 2^XLEN): 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 SLT signed (1/0);
//   6 SLTU unsigned; 7 SLL; 8 SRL; 9 SRA; shamt = b[$clog2(XLEN)-1:0]; 10-15 -> result 0.
//  Arithmetic done in stage 1; remaining stages carry result+tag unchanged.
//  flush: at the edge, clears pipeline, queue, cnt; accept in the same cycle is dropped;
//   cdb_req=0, issue_ready=1 next cycle. flush has priority over grant.
//  busy = (cnt != 0).
// TESTING
//  LAT=2: ADD 5,7 tag 3 at edge 0 -> cdb_req=1 after edge 2, result 0x0000000C, tag 3; grant -> cdb_req=0.
//  SUB 0,1 -> 0xFFFFFFFF; ADD 0xFFFFFFFF,1 -> 0; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0; SRA 0x80000000,4 -> 0xF8000000.
//  Grant held 0, OUTQ_DEPTH=2, issue tags 1,2,3 back-to-back -> ready low after 2 accepts;
//   tag 3 waits; grants then yield tags 1,2,3 in order.
//  Full queue, grant and new accept same cycle -> no loss, cnt stable, order preserved.
//  flush with 1 in flight + 1 queued -> cdb_req=0 next cycle, no stale broadcast, ready=1.
//  Assert reset with queued op and cdb_req=1 -> all outputs to reset values immediately (async).

Source files
------------

// File: rtl/int_alu_fu.sv
// Pipelined integer ALU functional unit.
// Accepts one op per cycle and computes it in stage 1. The result and tag are
// then carried through the rest of a LATENCY-deep pipeline into an in-order
// output queue, which waits for the CDB arbiter to grant a broadcast slot.
// A credit counter covers ops that are in flight plus ops that are queued.
// Because of it, an accepted op always has a queue slot, and the pipeline
// never has to stall.
module int_alu_fu #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned OUTQ_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [3:0]       issue_op,
    input  logic [XLEN-1:0]  issue_a,
    input  logic [XLEN-1:0]  issue_b,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             cdb_req,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_result,
    input  logic             cdb_grant,
    output logic             busy
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);
    localparam int unsigned CNT_W   = $clog2(OUTQ_DEPTH + 1);
    localparam int unsigned PTR_W   = (OUTQ_DEPTH > 1) ? $clog2(OUTQ_DEPTH) : 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9
    } alu_op_e;

    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               grant;
    logic               push;
    logic [XLEN-1:0]    alu_res;
    logic [SHAMT_W-1:0] shamt;

    logic               s_valid [LATENCY];
    logic [TAG_W-1:0]   s_tag   [LATENCY];
    logic [XLEN-1:0]    s_res   [LATENCY];

    logic [TAG_W-1:0]   q_tag   [OUTQ_DEPTH];
    logic [XLEN-1:0]    q_res   [OUTQ_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   qcnt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on the registered credit count. A grant in the same
    // cycle frees a credit, but ready does not rise until the next cycle.
    assign issue_ready = (cnt < CNT_W'(OUTQ_DEPTH));
    assign accept      = issue_valid & issue_ready;
    assign grant       = cdb_req & cdb_grant;
    assign push        = s_valid[LATENCY-1];
    assign busy        = (cnt != '0);

    assign cdb_req     = (qcnt != '0);
    assign cdb_tag     = cdb_req ? q_tag[rd_ptr] : '0;
    assign cdb_result  = cdb_req ? q_res[rd_ptr] : '0;

    // Stage-1 arithmetic on the incoming operands.
    always_comb begin
        alu_res = '0;
        shamt   = issue_b[SHAMT_W-1:0];
        case (issue_op)
            OP_ADD:  alu_res = issue_a + issue_b;
            OP_SUB:  alu_res = issue_a - issue_b;
            OP_AND:  alu_res = issue_a & issue_b;
            OP_OR:   alu_res = issue_a | issue_b;
            OP_XOR:  alu_res = issue_a ^ issue_b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(issue_a) < $signed(issue_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (issue_a < issue_b)};
            OP_SLL:  alu_res = issue_a << shamt;
            OP_SRL:  alu_res = issue_a >> shamt;
            OP_SRA:  alu_res = XLEN'($signed(issue_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // Pipeline: stage 0 captures the accepted op; later stages pass it along unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                s_valid[i] <= 1'b0;
                s_tag[i]   <= '0;
                s_res[i]   <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                s_valid[i] <= 1'b0;
            end
        end else begin
            s_valid[0] <= accept;
            s_tag[0]   <= issue_tag;
            s_res[0]   <= alu_res;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                s_valid[i] <= s_valid[i-1];
                s_tag[i]   <= s_tag[i-1];
                s_res[i]   <= s_res[i-1];
            end
        end
    end

    // Output FIFO: push from the last pipeline stage, pop on grant. A flush
    // takes priority over a grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < OUTQ_DEPTH; i++) begin
                q_tag[i] <= '0;
                q_res[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            qcnt   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            qcnt   <= '0;
        end else begin
            if (push) begin
                q_tag[wr_ptr] <= s_tag[LATENCY-1];
                q_res[wr_ptr] <= s_res[LATENCY-1];
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (grant) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, grant})
                2'b10:   qcnt <= qcnt + 1'b1;
                2'b01:   qcnt <= qcnt - 1'b1;
                default: qcnt <= qcnt;
            endcase
        end
    end

    // Credit count of ops in flight plus queued: +1 on accept, -1 on grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case ({accept, grant})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule
